// File: rtl/dcache_access_unit.sv
// Memory-stage data-cache access unit: byte masks, store alignment, load extension and a stall handshake.
// Optional build macro MISALIGN_TRAP_EN adds misaligned-access trapping and the misalign_err port.
module dcache_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  mem_funct3,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        mem_done,
`ifdef MISALIGN_TRAP_EN
   output logic        misalign_err,
`endif
   output logic        data_read,
   output logic        data_write,
   output logic [31:0] data_addr,
   output logic [3:0]  data_mbe,
   output logic [31:0] data_wdata,
   input  logic [31:0] data_rdata,
   input  logic        data_resp
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic        data_read_q;
   logic        data_write_q;
   logic [31:0] data_addr_q;
   logic [3:0]  data_mbe_q;
   logic [31:0] data_wdata_q;
   logic [31:0] load_data_q;
   logic        mem_done_q;
   logic        misalign_q;

   logic        op_d;
   logic        mis_d;
   logic        issue_d;
   logic [3:0]  mbe_d;
   logic [31:0] wdata_d;
   logic [31:0] load_d;

   function automatic logic [3:0] calc_mbe(input logic [2:0] f3, input logic [1:0] o);
      logic [3:0] m;
      case (f3[1:0])
         2'b00:   m = 4'b0001 << o;
         2'b01:   m = 4'b0011 << {o[1], 1'b0};
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] align_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      case (f3[1:0])
         2'b00:   r = {4{wd[7:0]}};
         2'b01:   r = {2{wd[15:0]}};
         default: r = wd;
      endcase
      return r;
   endfunction

   // funct3[2] selects zero extension (bu/hu).
   function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] o,
                                                input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = rd[{o, 3'b000} +: 8];
      h = o[1] ? rd[31:16] : rd[15:0];
      case (f3[1:0])
         2'b00:   r = {{24{b[7] & ~f3[2]}}, b};
         2'b01:   r = {{16{h[15] & ~f3[2]}}, h};
         default: r = rd;
      endcase
      return r;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] o);
      logic m;
      case (f3[1:0])
         2'b01:   m = o[0];
         2'b10:   m = (o != 2'b00);
         default: m = 1'b0;
      endcase
      return m;
   endfunction

   // Request decode, alignment helpers and the combinational stall.
   always_comb begin
      op_d    = mem_valid & (mem_read | mem_write);
      mbe_d   = calc_mbe(mem_funct3, mem_addr[1:0]);
      wdata_d = align_wdata(mem_funct3, mem_wdata);
      load_d  = extract_load(mem_funct3, mem_addr[1:0], data_rdata);
`ifdef MISALIGN_TRAP_EN
      mis_d   = op_d & is_misaligned(mem_funct3, mem_addr[1:0]);
`else
      mis_d   = 1'b0;
`endif
      issue_d = op_d & ~mis_d;
      if (rst) begin
         stall = 1'b0;
      end else begin
         stall = ((state_q == IDLE) & issue_d) | (state_q == BUSY);
      end
   end

   // Access FSM with registered request and response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         data_read_q  <= 1'b0;
         data_write_q <= 1'b0;
         data_addr_q  <= 32'h0000_0000;
         data_mbe_q   <= 4'b0000;
         data_wdata_q <= 32'h0000_0000;
         load_data_q  <= 32'h0000_0000;
         mem_done_q   <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         mem_done_q  <= 1'b0;
         load_data_q <= 32'h0000_0000;
         misalign_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (issue_d) begin
                  data_read_q  <= mem_read;
                  data_write_q <= mem_write & ~mem_read;
                  data_addr_q  <= {mem_addr[31:2], 2'b00};
                  data_mbe_q   <= mbe_d;
                  data_wdata_q <= wdata_d;
                  state_q      <= BUSY;
               end else begin
                  misalign_q   <= mis_d;
                  state_q      <= IDLE;
               end
            end
            BUSY: begin
               if (data_resp) begin
                  // Stores return zero so load_data is only non-zero for loads.
                  load_data_q  <= data_read_q ? load_d : 32'h0000_0000;
                  mem_done_q   <= 1'b1;
                  data_read_q  <= 1'b0;
                  data_write_q <= 1'b0;
                  data_addr_q  <= 32'h0000_0000;
                  data_mbe_q   <= 4'b0000;
                  data_wdata_q <= 32'h0000_0000;
                  state_q      <= DONE;
               end else begin
                  state_q      <= BUSY;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               data_read_q  <= 1'b0;
               data_write_q <= 1'b0;
               data_addr_q  <= 32'h0000_0000;
               data_mbe_q   <= 4'b0000;
               data_wdata_q <= 32'h0000_0000;
               state_q      <= IDLE;
            end
         endcase
      end
   end

   assign data_read  = data_read_q;
   assign data_write = data_write_q;
   assign data_addr  = data_addr_q;
   assign data_mbe   = data_mbe_q;
   assign data_wdata = data_wdata_q;
   assign load_data  = load_data_q;
   assign mem_done   = mem_done_q;
`ifdef MISALIGN_TRAP_EN
   assign misalign_err = misalign_q;
`else
   logic unused_s;
   assign unused_s = misalign_q;
`endif

endmodule
